// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared widths and FSM state encoding for the cache controller
package cache_ctrl_pkg;
    localparam int CC_ADDR_W = 16;
    localparam int CC_DATA_W = 16;
    localparam int CC_IDX_W  = 4;
    localparam int CC_TAG_W  = CC_ADDR_W - CC_IDX_W - 2;
    typedef enum logic [1:0] {IDLE, COMPARE, MEM_RD, MEM_WR} state_t;
endpackage

// File: rtl/cache_ctrl_tag_store.sv
// cache_tag_store: valid+tag array, synchronous write, combinational read, cleared by rst
module cache_tag_store #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic             we,
    input  logic [TAG_W-1:0] wr_tag,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag
);
    logic [(1<<IDX_W)-1:0] valid;
    logic [TAG_W-1:0]      tags [1<<IDX_W];
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[idx] <= 1'b1;
            tags[idx]  <= wr_tag;
        end
    end
    assign rd_valid = valid[idx];
    assign rd_tag   = tags[idx];
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-through no-write-allocate controller; CACHE_CTRL_STATS_EN adds hit/miss counters
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W = CC_ADDR_W,
    parameter int DATA_W = CC_DATA_W,
    parameter int IDX_W  = CC_IDX_W,
    parameter int TAG_W  = CC_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_add,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cache_we,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_CTRL_STATS_EN
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
`endif
    input  logic              mem_ack
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] req_add;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              tag_valid, hit, refill;
    logic [TAG_W-1:0]  tag_rd;
    wire  [IDX_W-1:0]  req_idx = req_add[IDX_W+1:2];
    wire  [TAG_W-1:0]  req_tag = req_add[ADDR_W-1:IDX_W+2];

    cache_tag_store #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
        .clk(clk), .rst(rst), .idx(req_idx), .we(refill), .wr_tag(req_tag),
        .rd_valid(tag_valid), .rd_tag(tag_rd)
    );

    assign hit         = tag_valid && (tag_rd == req_tag);
    assign refill      = (state == MEM_RD) && mem_ack;
    assign ram_add     = req_add;
    assign mem_add     = req_add;
    assign mem_wdata   = req_wdata;
    assign ram_data_in = (state == MEM_RD) ? mem_rdata : req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_add   <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && cpu_req) begin
                req_add   <= cpu_add;
                req_we    <= cpu_we;
                req_wdata <= cpu_wdata;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        cache_we  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE:    state_n = cpu_req ? COMPARE : IDLE;
            COMPARE: begin
                cache_we  = req_we && hit;
                cpu_ready = !req_we && hit;
                cpu_rdata = (!req_we && hit) ? ram_data_out : '0;
                state_n   = req_we ? MEM_WR : (hit ? IDLE : MEM_RD);
            end
            MEM_RD:  begin
                mem_req   = 1'b1;
                cache_we  = mem_ack;
                cpu_ready = mem_ack;
                cpu_rdata = mem_ack ? mem_rdata : '0;
                state_n   = mem_ack ? IDLE : MEM_RD;
            end
            MEM_WR:  begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                cpu_ready = mem_ack;
                state_n   = mem_ack ? IDLE : MEM_WR;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == COMPARE) begin
            if (hit) hit_cnt <= hit_cnt + {15'd0, hit_cnt != 16'hFFFF};
            else     miss_cnt <= miss_cnt + {15'd0, miss_cnt != 16'hFFFF};
        end
    end
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with behavioural data RAM and main memory
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_add = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata, ram_add, ram_data_in, ram_data_out, mem_add, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        cpu_ready, cache_we, mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic [15:0] ram [16];
    int          vecs = 0, errs = 0;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_add(cpu_add),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cache_we(cache_we),
        .ram_add(ram_add), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_add(mem_add), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef CACHE_CTRL_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (cache_we) ram[ram_add[5:2]] <= ram_data_in;
    assign ram_data_out = ram[ram_add[5:2]];

    // Issues one request at a negedge and plays main memory: ack after ack_dly mem_req cycles
    task automatic run_req(input logic we, input logic [15:0] add, input logic [15:0] wd,
                           input int ack_dly, input logic [15:0] ack_data,
                           output int lat, output int mreq, output int cwe, output logic [15:0] rdata,
                           output logic mwe, output logic [15:0] madd, output logic [15:0] mwd,
                           output logic to);
        lat = 0; mreq = 0; cwe = 0; rdata = '0; mwe = 0; madd = '0; mwd = '0; to = 1;
        cpu_req = 1; cpu_we = we; cpu_add = add; cpu_wdata = wd;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            mem_ack = 0;
            if (mem_req) begin
                mreq++;
                mwe = mwe | mem_we; madd = mem_add; mwd = mem_wdata;
                if (mreq == ack_dly) begin mem_ack = 1; mem_rdata = ack_data; end
            end
            #1;
            if (cache_we) cwe++;
            if (cpu_ready) begin rdata = cpu_rdata; to = 0; break; end
        end
        cpu_req = 0;
        @(posedge clk); @(negedge clk);
        mem_ack = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vecs++; if ({cpu_ready, cache_we, mem_req, mem_we} !== 4'b0) begin errs++; $display("FAIL reset_ctl got %b want 0000", {cpu_ready, cache_we, mem_req, mem_we}); end
        vecs++; if ({cpu_rdata, ram_data_in, mem_wdata, mem_add} !== 64'd0) begin errs++; $display("FAIL reset_data got %h want 0", {cpu_rdata, ram_data_in, mem_wdata, mem_add}); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_load_miss;
        int lat, mreq, cwe; logic [15:0] rd, madd, mwd; logic mwe, to;
        run_req(0, 16'h0104, 0, 3, 16'hBEEF, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (to !== 0 || lat !== 4) begin errs++; $display("FAIL miss_lat got %0d to=%b want 4", lat, to); end
        vecs++; if (mreq !== 3 || mwe !== 0) begin errs++; $display("FAIL miss_memreq got %0d we=%b want 3 we=0", mreq, mwe); end
        vecs++; if (cwe !== 1) begin errs++; $display("FAIL miss_cwe got %0d want 1", cwe); end
        vecs++; if (rd !== 16'hBEEF || madd !== 16'h0104) begin errs++; $display("FAIL miss_data got %h @%h want beef @0104", rd, madd); end
        vecs++; if (ram[1] !== 16'hBEEF) begin errs++; $display("FAIL miss_ram got %h want beef", ram[1]); end
    endtask

    task automatic test_load_hit_evict;
        int lat, mreq, cwe; logic [15:0] rd, madd, mwd; logic mwe, to;
        run_req(0, 16'h0104, 0, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (to !== 0 || lat !== 1 || mreq !== 0) begin errs++; $display("FAIL hit_lat got %0d mreq %0d want 1/0", lat, mreq); end
        vecs++; if (rd !== 16'hBEEF) begin errs++; $display("FAIL hit_data got %h want beef", rd); end
        run_req(0, 16'h0144, 0, 2, 16'hCAFE, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (lat !== 3 || mreq !== 2 || rd !== 16'hCAFE) begin errs++; $display("FAIL conflict_miss got lat %0d mreq %0d %h want 3/2/cafe", lat, mreq, rd); end
        run_req(0, 16'h0104, 0, 1, 16'hBEEF, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (lat !== 2 || mreq !== 1 || rd !== 16'hBEEF) begin errs++; $display("FAIL evicted_miss got lat %0d mreq %0d %h want 2/1/beef", lat, mreq, rd); end
    endtask

    task automatic test_store_hit;
        int lat, mreq, cwe; logic [15:0] rd, madd, mwd; logic mwe, to;
        run_req(1, 16'h0104, 16'h1234, 2, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (cwe !== 1 || lat !== 3 || mreq !== 2) begin errs++; $display("FAIL st_hit_ctl got cwe %0d lat %0d mreq %0d want 1/3/2", cwe, lat, mreq); end
        vecs++; if (mwe !== 1 || madd !== 16'h0104 || mwd !== 16'h1234) begin errs++; $display("FAIL st_hit_mem got we %b %h/%h want 1 0104/1234", mwe, madd, mwd); end
        run_req(0, 16'h0104, 0, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (lat !== 1 || rd !== 16'h1234) begin errs++; $display("FAIL st_hit_reload got lat %0d %h want 1/1234", lat, rd); end
    endtask

    task automatic test_store_miss;
        int lat, mreq, cwe; logic [15:0] rd, madd, mwd; logic mwe, to;
        run_req(1, 16'h2008, 16'h5555, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (cwe !== 0 || lat !== 2) begin errs++; $display("FAIL st_miss_ctl got cwe %0d lat %0d want 0/2", cwe, lat); end
        vecs++; if (mwe !== 1 || madd !== 16'h2008 || mwd !== 16'h5555) begin errs++; $display("FAIL st_miss_mem got we %b %h/%h want 1 2008/5555", mwe, madd, mwd); end
        run_req(0, 16'h2008, 0, 1, 16'h7777, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (lat !== 2 || mreq !== 1 || rd !== 16'h7777) begin errs++; $display("FAIL st_miss_load got lat %0d mreq %0d %h want 2/1/7777", lat, mreq, rd); end
    endtask

    task automatic test_back_to_back;
        cpu_req = 1; cpu_we = 0; cpu_add = 16'h0104;
        @(posedge clk); @(negedge clk); #1;
        vecs++; if (cpu_ready !== 1 || cpu_rdata !== 16'h1234) begin errs++; $display("FAIL b2b_first got %b %h want 1 1234", cpu_ready, cpu_rdata); end
        cpu_add = 16'h2008;
        @(posedge clk); @(negedge clk); #1;
        vecs++; if (cpu_ready !== 0) begin errs++; $display("FAIL b2b_gap got %b want 0", cpu_ready); end
        @(posedge clk); @(negedge clk); #1;
        vecs++; if (cpu_ready !== 1 || cpu_rdata !== 16'h7777) begin errs++; $display("FAIL b2b_second got %b %h want 1 7777", cpu_ready, cpu_rdata); end
        cpu_req = 0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_stray_ack;
        int lat, mreq, cwe; logic [15:0] rd, madd, mwd; logic mwe, to;
        mem_ack = 1; mem_rdata = 16'hDEAD;
        repeat (2) begin
            @(posedge clk); @(negedge clk); #1;
            vecs++; if ({cpu_ready, cache_we, mem_req} !== 3'b000) begin errs++; $display("FAIL stray_ack got %b want 000", {cpu_ready, cache_we, mem_req}); end
        end
        mem_ack = 0;
        run_req(0, 16'h0104, 0, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (mreq !== 0 || rd !== 16'h1234) begin errs++; $display("FAIL stray_after got mreq %0d %h want 0/1234", mreq, rd); end
    endtask

    task automatic test_reset_mid_miss;
        int lat, mreq, cwe; logic [15:0] rd, madd, mwd; logic mwe, to;
        cpu_req = 1; cpu_we = 0; cpu_add = 16'h0300;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vecs++; if (mem_req !== 1) begin errs++; $display("FAIL rstmid_req got %b want 1", mem_req); end
        cpu_req = 0; rst = 1; mem_ack = 1; mem_rdata = 16'h9999;
        @(posedge clk); @(negedge clk); #1;
        vecs++; if ({mem_req, cpu_ready, cache_we} !== 3'b000) begin errs++; $display("FAIL rstmid_drop got %b want 000", {mem_req, cpu_ready, cache_we}); end
        rst = 0; mem_ack = 0;
        @(negedge clk);
        run_req(0, 16'h0300, 0, 1, 16'h3333, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (mreq !== 1 || rd !== 16'h3333) begin errs++; $display("FAIL rstmid_reload got mreq %0d %h want 1/3333", mreq, rd); end
        run_req(0, 16'h0104, 0, 1, 16'h4444, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (mreq !== 1 || rd !== 16'h4444) begin errs++; $display("FAIL rstmid_cleared got mreq %0d %h want 1/4444", mreq, rd); end
    endtask

`ifdef CACHE_CTRL_STATS_EN
    task automatic test_stats;
        int lat, mreq, cwe; logic [15:0] rd, madd, mwd; logic mwe, to;
        rst = 1; @(posedge clk); @(negedge clk); rst = 0;
        run_req(0, 16'h0104, 0, 1, 16'h1111, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        run_req(0, 16'h0104, 0, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        run_req(0, 16'h0144, 0, 1, 16'h2222, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        run_req(0, 16'h0144, 0, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        run_req(1, 16'h2008, 16'h1, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd3) begin errs++; $display("FAIL stats got %0d/%0d want 2/3", hit_cnt, miss_cnt); end
        force dut.hit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt;
        run_req(0, 16'h0144, 0, 1, 16'h0000, lat, mreq, cwe, rd, mwe, madd, mwd, to);
        vecs++; if (hit_cnt !== 16'hFFFF) begin errs++; $display("FAIL stats_sat got %h want ffff", hit_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        @(negedge clk);
        test_reset;
        test_load_miss;
        test_load_hit_evict;
        test_store_hit;
        test_store_miss;
        test_back_to_back;
        test_stray_ack;
        test_reset_mid_miss;
`ifdef CACHE_CTRL_STATS_EN
        test_stats;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
